// File: rtl/uart_port_arbiter.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter
//
// Purpose:
//   Sequences the register port of a single UART on behalf of two byte-stream
//   transmit requesters and one receive sink. The block polls UART status
//   continuously. It drains received bytes into a one-entry holding register.
//   It grants transmit writes either round-robin or with fixed priority to
//   requester 0.
//
// Parameters:
//   RR_EN       1 = round-robin between req0/req1, 0 = req0 always wins
//
// Ports:
//   clk         in   system clock, all state changes on posedge
//   reset_n     in   asynchronous active-low reset
//   req0_valid  in   requester 0 has a TX byte (held until accepted)
//   req0_data   in   requester 0 byte (stable while req0_valid)
//   req0_ready  out  one-cycle accept strobe for requester 0
//   req1_valid  in   requester 1 has a TX byte
//   req1_data   in   requester 1 byte
//   req1_ready  out  one-cycle accept strobe for requester 1
//   rx_valid    out  rx_data holds an unconsumed byte
//   rx_data     out  received byte
//   rx_ready    in   sink consumes the byte when rx_valid & rx_ready at posedge
//   uart_cs     out  UART chip select
//   uart_rnw    out  UART read(1) / write(0)
//   uart_a0     out  UART address: 0 = status, 1 = data
//   uart_din    out  UART write data
//   uart_dout   in   UART read data (combinational); bit0 = rx_full, bit1 = tx_busy
// -----------------------------------------------------------------------------
module uart_port_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       uart_cs,
   output logic       uart_rnw,
   output logic       uart_a0,
   output logic [7:0] uart_din,
   input  logic [7:0] uart_dout
);

   typedef enum logic [2:0] {
      S_POLL   = 3'd0,
      S_RXCAP  = 3'd1,
      S_RXCLR  = 3'd2,
      S_TXWR   = 3'd3,
      S_SETTLE = 3'd4
   } state_t;

   state_t state;

   // Requester that wins the next tie: 0 = req0, 1 = req1.
   logic   rr_favour1;
   // Requester granted for the TXWR cycle in progress.
   logic   grant1;

   logic   rx_full;
   logic   tx_busy;
   logic   slot_free;
   logic   any_req;
   logic   pick1;

   assign rx_full   = uart_dout[0];
   assign tx_busy   = uart_dout[1];
   // The holding register can accept a new byte if it is empty or is being
   // consumed on this very edge.
   assign slot_free = !rx_valid || rx_ready;
   assign any_req   = req0_valid || req1_valid;
   // A lone requester always wins; on a tie the pointer decides (round-robin)
   // or req0 wins (fixed priority).
   assign pick1     = req1_valid && (!req0_valid || (RR_EN ? rr_favour1 : 1'b0));

   // Bus outputs are registered and loaded with the decode of the state being
   // entered. They are therefore a pure function of the state register and
   // cannot glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_POLL;
         rr_favour1 <= 1'b0;
         grant1     <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= 8'h00;
         uart_cs    <= 1'b0;
         uart_rnw   <= 1'b1;
         uart_a0    <= 1'b0;
         uart_din   <= 8'h00;
      end else begin
         // Accept strobes are single-cycle; only the POLL->TXWR transition
         // raises one of them.
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;

         // Consumption by the sink; a capture in RXCAP below overrides this
         // because it is the later assignment.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            S_POLL: begin
               // RX is served before TX so the UART receive buffer is never
               // overrun while transmit traffic is heavy.
               if (rx_full && slot_free) begin
                  state    <= S_RXCAP;
                  uart_cs  <= 1'b0;
                  uart_rnw <= 1'b1;
                  uart_a0  <= 1'b1;
               end else if (!tx_busy && any_req) begin
                  state      <= S_TXWR;
                  uart_cs    <= 1'b1;
                  uart_rnw   <= 1'b0;
                  uart_a0    <= 1'b1;
                  grant1     <= pick1;
                  uart_din   <= pick1 ? req1_data : req0_data;
                  req0_ready <= !pick1;
                  req1_ready <= pick1;
               end else begin
                  state    <= S_POLL;
                  uart_cs  <= 1'b1;
                  uart_rnw <= 1'b1;
                  uart_a0  <= 1'b0;
               end
            end

            S_RXCAP: begin
               // The UART data register clears inside its own cs read cycle,
               // so the byte is taken here with cs low and acknowledged next.
               rx_data  <= uart_dout;
               rx_valid <= 1'b1;
               state    <= S_RXCLR;
               uart_cs  <= 1'b1;
               uart_rnw <= 1'b1;
               uart_a0  <= 1'b1;
            end

            S_RXCLR: begin
               state    <= S_POLL;
               uart_cs  <= 1'b1;
               uart_rnw <= 1'b1;
               uart_a0  <= 1'b0;
            end

            S_TXWR: begin
               // The pointer moves only when a write actually happens.
               if (RR_EN) begin
                  rr_favour1 <= !grant1;
               end
               state    <= S_SETTLE;
               uart_cs  <= 1'b0;
               uart_rnw <= 1'b1;
               uart_a0  <= 1'b0;
            end

            S_SETTLE: begin
               // One idle cycle so tx_busy is visible at the next status read.
               state    <= S_POLL;
               uart_cs  <= 1'b1;
               uart_rnw <= 1'b1;
               uart_a0  <= 1'b0;
            end

            default: begin
               state    <= S_POLL;
               uart_cs  <= 1'b1;
               uart_rnw <= 1'b1;
               uart_a0  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_port_arbiter.sv
module tb_uart_port_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data = 8'h00;
   logic       req1_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready = 1'b0;
   logic       uart_cs;
   logic       uart_rnw;
   logic       uart_a0;
   logic [7:0] uart_din;
   logic [7:0] uart_dout;

   // Fixed-priority instance, UART always idle with nothing received.
   logic       fp_req0_valid = 1'b0;
   logic [7:0] fp_req0_data = 8'hA1;
   logic       fp_req0_ready;
   logic       fp_req1_valid = 1'b0;
   logic [7:0] fp_req1_data = 8'hB2;
   logic       fp_req1_ready;
   logic       fp_rx_valid;
   logic [7:0] fp_rx_data;
   logic       fp_rx_ready = 1'b0;
   logic       fp_cs;
   logic       fp_rnw;
   logic       fp_a0;
   logic [7:0] fp_din;
   logic [7:0] fp_dout;

   int tests_run = 0;
   int tests_failed = 0;

   // UART model
   logic       m_rx_full = 1'b0;
   logic [7:0] m_rx_byte = 8'h00;
   int         m_busy_cnt = 0;
   int         tx_busy_len = 0;
   logic       inj_req = 1'b0;
   logic [7:0] inj_byte = 8'h00;

   // Scoreboard queues
   logic [7:0] tx_exp[$];
   logic [7:0] tx_obs[$];
   logic [7:0] rx_exp[$];
   logic [7:0] rx_obs[$];
   logic [7:0] fp_obs[$];
   int         fp_r1_cnt = 0;
   int         viol = 0;

   always #5 clk = ~clk;

   uart_port_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .uart_cs(uart_cs), .uart_rnw(uart_rnw), .uart_a0(uart_a0),
      .uart_din(uart_din), .uart_dout(uart_dout)
   );

   uart_port_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(fp_req0_valid), .req0_data(fp_req0_data), .req0_ready(fp_req0_ready),
      .req1_valid(fp_req1_valid), .req1_data(fp_req1_data), .req1_ready(fp_req1_ready),
      .rx_valid(fp_rx_valid), .rx_data(fp_rx_data), .rx_ready(fp_rx_ready),
      .uart_cs(fp_cs), .uart_rnw(fp_rnw), .uart_a0(fp_a0),
      .uart_din(fp_din), .uart_dout(fp_dout)
   );

   assign uart_dout = uart_a0 ? m_rx_byte : {6'b0, (m_busy_cnt != 0), m_rx_full};
   assign fp_dout   = 8'h00;

   always @(posedge clk) begin
      if (inj_req) begin
         m_rx_full <= 1'b1;
         m_rx_byte <= inj_byte;
      end else if (uart_cs && uart_rnw && uart_a0) begin
         m_rx_full <= 1'b0;
      end
      if (uart_cs && !uart_rnw && uart_a0) begin
         tx_obs.push_back(uart_din);
         m_busy_cnt <= tx_busy_len;
      end else if (m_busy_cnt != 0) begin
         m_busy_cnt <= m_busy_cnt - 1;
      end
      if (rx_valid && rx_ready) rx_obs.push_back(rx_data);
      if (fp_cs && !fp_rnw && fp_a0) fp_obs.push_back(fp_din);
      if (fp_req1_ready) fp_r1_cnt <= fp_r1_cnt + 1;
      if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && uart_rnw) ||
          (fp_req0_ready && fp_req1_ready) || ((fp_req0_ready || fp_req1_ready) && fp_rnw) ||
          fp_rx_valid || (fp_rx_data != 8'h00))
         viol <= viol + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rx_ready = 1'b0;
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; inj_req = 1'b0;
      tx_busy_len = 0;
      repeat (2) @(posedge clk);
      #1;
      tx_obs.delete(); rx_obs.delete(); fp_obs.delete();
      tx_exp.delete(); rx_exp.delete();
      reset_n = 1'b1;
   endtask

   task automatic inject_rx(input logic [7:0] b);
      inj_byte = b;
      inj_req = 1'b1;
      @(posedge clk);
      #1;
      inj_req = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      @(posedge clk);
      #1;
      tests_run++; if (uart_cs !== 1'b0) begin tests_failed++; $display("FAIL reset_cs got %b want 0", uart_cs); end
      tests_run++; if (uart_rnw !== 1'b1) begin tests_failed++; $display("FAIL reset_rnw got %b want 1", uart_rnw); end
      tests_run++; if (uart_a0 !== 1'b0) begin tests_failed++; $display("FAIL reset_a0 got %b want 0", uart_a0); end
      tests_run++; if (uart_din !== 8'h00) begin tests_failed++; $display("FAIL reset_din got %h want 00", uart_din); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
      tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
   endtask

   task automatic test_single_tx();
      do_reset();
      req0_data = 8'h55; req0_valid = 1'b1;
      tx_exp.push_back(8'h55);
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_rnw, uart_a0} !== 3'b101) begin tests_failed++; $display("FAIL txwr_bus got %b want 101", {uart_cs, uart_rnw, uart_a0}); end
      tests_run++; if (uart_din !== 8'h55) begin tests_failed++; $display("FAIL txwr_din got %h want 55", uart_din); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL txwr_ready got %b want 10", {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      tests_run++; if ({uart_cs, req0_ready} !== 2'b00) begin tests_failed++; $display("FAIL settle_cs_ready got %b want 00", {uart_cs, req0_ready}); end
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_rnw, uart_a0} !== 3'b110) begin tests_failed++; $display("FAIL poll_bus got %b want 110", {uart_cs, uart_rnw, uart_a0}); end
      repeat (4) @(posedge clk); #1;
      tests_run++; if (tx_obs.size() !== 1) begin tests_failed++; $display("FAIL single_tx_count got %0d want 1", tx_obs.size()); end
      while (tx_obs.size() > 0 && tx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = tx_obs.pop_front(); e = tx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL single_tx_byte got %h want %h", o, e); end
      end
   endtask

   task automatic test_round_robin();
      bit done;
      do_reset();
      tx_busy_len = 2;
      req0_data = 8'hA1; req1_data = 8'hB2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      tx_exp.push_back(8'hA1); tx_exp.push_back(8'hB2);
      tx_exp.push_back(8'hA1); tx_exp.push_back(8'hB2);
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (tx_obs.size() >= 4) begin done = 1'b1; break; end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL rr_timeout got %0d writes want 4", tx_obs.size()); end
      repeat (10) @(posedge clk); #1;
      tests_run++; if (tx_obs.size() !== 4) begin tests_failed++; $display("FAIL rr_count got %0d want 4", tx_obs.size()); end
      while (tx_obs.size() > 0 && tx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = tx_obs.pop_front(); e = tx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL rr_byte got %h want %h", o, e); end
      end
      tx_busy_len = 0;
   endtask

   task automatic test_fixed_priority();
      int r1_before;
      do_reset();
      r1_before = fp_r1_cnt;
      fp_req0_valid = 1'b1; fp_req1_valid = 1'b1;
      repeat (30) @(posedge clk); #1;
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
      repeat (5) @(posedge clk); #1;
      tests_run++; if (fp_obs.size() < 5) begin tests_failed++; $display("FAIL fp_count got %0d want >=5", fp_obs.size()); end
      tests_run++; if (fp_r1_cnt - r1_before !== 0) begin tests_failed++; $display("FAIL fp_req1_ready got %0d pulses want 0", fp_r1_cnt - r1_before); end
      while (fp_obs.size() > 0) begin
         logic [7:0] o;
         o = fp_obs.pop_front();
         tests_run++; if (o !== 8'hA1) begin tests_failed++; $display("FAIL fp_byte got %h want a1", o); end
      end
   endtask

   task automatic test_rx_basic();
      do_reset();
      rx_ready = 1'b1;
      rx_exp.push_back(8'h3C);
      inject_rx(8'h3C);
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_rnw, uart_a0} !== 3'b011) begin tests_failed++; $display("FAIL rxcap_bus got %b want 011", {uart_cs, uart_rnw, uart_a0}); end
      @(posedge clk); #1;
      tests_run++; if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin tests_failed++; $display("FAIL rx_hold got %b/%h want 1/3c", rx_valid, rx_data); end
      tests_run++; if ({uart_cs, uart_rnw, uart_a0} !== 3'b111) begin tests_failed++; $display("FAIL rxclr_bus got %b want 111", {uart_cs, uart_rnw, uart_a0}); end
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_a0, rx_valid} !== 3'b100) begin tests_failed++; $display("FAIL rx_poll_after got %b want 100", {uart_cs, uart_a0, rx_valid}); end
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_a0} !== 2'b10) begin tests_failed++; $display("FAIL rx_full_cleared got %b want 10", {uart_cs, uart_a0}); end
      tests_run++; if (rx_obs.size() !== 1) begin tests_failed++; $display("FAIL rx_count got %0d want 1", rx_obs.size()); end
      while (rx_obs.size() > 0 && rx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = rx_obs.pop_front(); e = rx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL rx_byte got %h want %h", o, e); end
      end
      rx_ready = 1'b0;
   endtask

   task automatic test_rx_backpressure();
      bit serviced;
      do_reset();
      rx_ready = 1'b0;
      rx_exp.push_back(8'h11); rx_exp.push_back(8'h22);
      inject_rx(8'h11);
      repeat (3) @(posedge clk); #1;
      inject_rx(8'h22);
      serviced = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (uart_a0 !== 1'b0) serviced = 1'b1;
      end
      tests_run++; if (serviced !== 1'b0) begin tests_failed++; $display("FAIL bp_no_service got %b want 0", serviced); end
      tests_run++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin tests_failed++; $display("FAIL bp_hold got %b/%h want 1/11", rx_valid, rx_data); end
      rx_ready = 1'b1;
      repeat (6) @(posedge clk); #1;
      rx_ready = 1'b0;
      tests_run++; if (rx_obs.size() !== 2) begin tests_failed++; $display("FAIL bp_count got %0d want 2", rx_obs.size()); end
      while (rx_obs.size() > 0 && rx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = rx_obs.pop_front(); e = rx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL bp_byte got %h want %h", o, e); end
      end
   endtask

   task automatic test_rx_priority();
      bit got;
      do_reset();
      rx_ready = 1'b1;
      rx_exp.push_back(8'h5A);
      tx_exp.push_back(8'hC3);
      inject_rx(8'h5A);
      req1_data = 8'hC3; req1_valid = 1'b1;
      @(posedge clk); #1;
      tests_run++; if ({uart_cs, uart_a0, req1_ready} !== 3'b010) begin tests_failed++; $display("FAIL prio_rxcap got %b want 010", {uart_cs, uart_a0, req1_ready}); end
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (req1_ready === 1'b1) begin got = 1'b1; break; end
      end
      tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL prio_tx_late got %b want 1", got); end
      tests_run++; if (uart_din !== 8'hC3) begin tests_failed++; $display("FAIL prio_din got %h want c3", uart_din); end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      rx_ready = 1'b0;
      tests_run++; if ({tx_obs.size(), rx_obs.size()} !== {32'd1, 32'd1}) begin tests_failed++; $display("FAIL prio_counts got tx %0d rx %0d want 1 1", tx_obs.size(), rx_obs.size()); end
      while (tx_obs.size() > 0 && tx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = tx_obs.pop_front(); e = tx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL prio_tx_byte got %h want %h", o, e); end
      end
      while (rx_obs.size() > 0 && rx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = rx_obs.pop_front(); e = rx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL prio_rx_byte got %h want %h", o, e); end
      end
   endtask

   task automatic test_reset_during_tx();
      bit got;
      do_reset();
      rx_ready = 1'b0;
      inject_rx(8'h99);
      repeat (3) @(posedge clk); #1;
      tests_run++; if ({rx_valid, rx_data} !== {1'b1, 8'h99}) begin tests_failed++; $display("FAIL mid_rx_hold got %b/%h want 1/99", rx_valid, rx_data); end
      req0_data = 8'h77; req0_valid = 1'b1;
      tx_exp.push_back(8'h77);
      @(posedge clk); #1;
      tests_run++; if ({uart_rnw, req0_ready} !== 2'b01) begin tests_failed++; $display("FAIL mid_txwr got %b want 01", {uart_rnw, req0_ready}); end
      reset_n = 1'b0;
      #1;
      tests_run++; if ({uart_cs, uart_rnw, uart_a0, req0_ready, req1_ready} !== 5'b01000) begin tests_failed++; $display("FAIL mid_reset_ctrl got %b want 01000", {uart_cs, uart_rnw, uart_a0, req0_ready, req1_ready}); end
      tests_run++; if ({uart_din, rx_valid, rx_data} !== 17'h0) begin tests_failed++; $display("FAIL mid_reset_data got %h/%b/%h want 00/0/00", uart_din, rx_valid, rx_data); end
      @(posedge clk); #1;
      tests_run++; if (tx_obs.size() !== 0) begin tests_failed++; $display("FAIL mid_no_write got %0d want 0", tx_obs.size()); end
      reset_n = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (req0_ready === 1'b1) begin got = 1'b1; break; end
      end
      tests_run++; if (got !== 1'b1) begin tests_failed++; $display("FAIL mid_retry_timeout got %b want 1", got); end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (6) @(posedge clk); #1;
      tests_run++; if (tx_obs.size() !== 1) begin tests_failed++; $display("FAIL mid_dup got %0d writes want 1", tx_obs.size()); end
      while (tx_obs.size() > 0 && tx_exp.size() > 0) begin
         logic [7:0] o, e;
         o = tx_obs.pop_front(); e = tx_exp.pop_front();
         tests_run++; if (o !== e) begin tests_failed++; $display("FAIL mid_byte got %h want %h", o, e); end
      end
   endtask

   task automatic test_invariants();
      tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL ready_invariant got %0d violations want 0", viol); end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_round_robin();
      test_fixed_priority();
      test_rx_basic();
      test_rx_backpressure();
      test_rx_priority();
      test_reset_during_tx();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
